rtc_bus_master: RTL and testbench
=================================

# rtc_bus_master

Parametrised bus master for the RTC chip's multiplexed address/data interface, driving ADo/CSo/RDo/WRo and the shared AdressDatao bus. It sits between the controller's init/read/write sequencing FSMs and the chip pins. It replaces the fixed single-register, fixed-timing read/write state machines with one engine. The engine supports configurable data width, configurable per-phase timing, and auto-incrementing burst transfers of up to MAX_BURST registers.

## Interface
Parameters:
- DATA_W, 8, address and data bus width.
- T_SETUP, 1, cycles of setup before each strobe; must be ≥1.
- T_STROBE, 4, cycles CSo and RDo/WRo are held low; must be ≥1.
- T_HOLD, 1, cycles after the strobe is released with the bus still driven; must be ≥1.
- T_GAP, 2, idle cycles between beats of a burst; must be ≥1.
- MAX_BURST, 16, maximum beats per request.

Ports:
- clock, in, 1, system clock. One clock domain only.
- reset, in, 1, synchronous, active-low. Sampled only on the rising edge of clock.
- start, in, 1, request strobe. Accepted only when busy=0.
- rw, in, 1, transfer direction: 1=read, 0=write. Sampled at accept.
- addr, in, DATA_W, first register address. Sampled at accept.
- len, in, clog2(MAX_BURST+1), number of beats. Sampled at accept.
- wdata, in, DATA_W, write data for the current beat.
- wdata_ack, out, 1, one-cycle pulse when wdata has been captured.
- rdata, out, DATA_W, read data. Valid only while rdata_valid=1.
- rdata_valid, out, 1, one-cycle pulse per read beat.
- busy, out, 1, high from the cycle after accept until done.
- done, out, 1, one-cycle pulse when the request completes.
- ADo, CSo, RDo, WRo, out, 1 each, chip strobes. All active-low.
- AdressDatao, out, DATA_W, value driven onto the shared bus.
- AdressData_in, in, DATA_W, value sampled from the shared bus.
- bus_oe, out, 1, output enable for the pad tristate.
- bstate, out, 4, current FSM state, exported for debug.

## Operation
States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP, DONE.

- **IDLE**
  - ADo=CSo=RDo=WRo=1, bus_oe=0, AdressDatao=0, busy=0.
  - start=1 → latch rw, addr and len into cur_addr, beats_left and the direction register, then go to A_SETUP.
  - If len=0, go to DONE directly; no bus activity occurs.
- **Address phase** (bus_oe=1, AdressDatao=cur_addr):
  - A_SETUP: ADo=0.
  - A_STROBE: ADo=0, CSo=0, WRo=0.
  - A_HOLD: all strobes high.
- **Data phase** (ADo=1):
  - D_SETUP, write: bus_oe=1, AdressDatao=wdata. wdata is captured on the first D_SETUP cycle and wdata_ack pulses in that cycle.
  - D_SETUP, read: bus_oe=0.
  - D_STROBE: CSo=0, plus WRo=0 for a write or RDo=0 for a read.
  - Read capture: AdressData_in is registered on the last D_STROBE cycle. rdata_valid pulses in the following cycle, which is the first D_HOLD cycle.
  - D_HOLD: strobes high. bus_oe stays 1 for a write and 0 for a read.
- **After D_HOLD:** decrement beats_left and set cur_addr = cur_addr+1, wrapping modulo 2^DATA_W (for example 0xFF→0x00).
  - beats_left≠0 → GAP (all strobes high, bus_oe=0), then A_SETUP.
  - beats_left=0 → DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE.
- **Phase durations:** each phase state lasts its T_* count, timed by a single down-counter reloaded on every state entry.
- **start while busy:** ignored. No queuing, no error.
- **len > MAX_BURST:** clamped to MAX_BURST.
- **reset=0 at any edge:**
  - Next cycle: IDLE, all strobes high, bus_oe=0, AdressDatao=0.
  - rdata=0, busy=0, done=0, wdata_ack=0, rdata_valid=0.
  - A partially completed burst is abandoned and no done pulse is issued.
- **Invariants:**
  - CSo and ADo never go low in the same cycle during the data phase.
  - RDo and WRo are never both low.
  - bus_oe=0 whenever RDo=0.

## Timing
- start is accepted at clock edge k. busy=1 and the first A_SETUP cycle both begin at k+1. All outputs are registered.
- Cycles per beat: B = 2·(T_SETUP+T_STROBE+T_HOLD). With default parameters, B=12.
- For a burst of N≥1 beats, done is high in cycle k+1 + N·B + (N−1)·T_GAP. busy falls in the cycle after done.
- For len=0, done is high in cycle k+1.
- A new start may be accepted in the cycle after done, i.e. back-to-back requests are allowed.

## Structure
- Package rtc_bus_pkg holds:
  - the state enum, with 4-bit encodings matching bstate;
  - default timing constants;
  - a compile-time clog2 helper function.
- Sub-module rtc_phase_timer: a loadable down-counter with a "last" flag, width clog2 of the largest T_* parameter. It is instantiated once.
- Parameter checks (every T_* ≥ 1, MAX_BURST ≥ 1) are elaboration-time assertions.

## Test plan
- **Single write:** reset low for 2 cycles; start, rw=0, addr=0x21, len=1, wdata=0x59.
  - Address phase drives AdressDatao=0x21; data phase drives AdressDatao=0x59.
  - WRo is low for 4 cycles in each phase.
  - wdata_ack pulses once; done is high exactly 13 cycles after accept.
- **Single read:** rw=1, addr=0x22, with the bus model returning 0x37.
  - rdata=0x37 with a single rdata_valid pulse.
  - bus_oe=0 throughout D_SETUP, D_STROBE and D_HOLD; RDo is low for 4 cycles.
- **Read burst with address wrap:** rw=1, addr=0xFE, len=3.
  - Address phases drive 0xFE, 0xFF, 0x00 in order.
  - Exactly three rdata_valid pulses.
  - done at cycle k+1+3·12+2·2 = k+41.
- **Boundary requests:**
  - len=0 → done at k+1, no strobe ever goes low.
  - start held high while busy → only one transaction occurs.
  - len=20 with MAX_BURST=16 → exactly 16 beats.
- **Mid-burst reset:** assert reset during D_STROBE of beat 2 of a 4-beat write.
  - Next cycle: all strobes high, bus_oe=0, bstate=IDLE, no done pulse.
  - A new request is accepted normally afterwards.
- **Re-parametrisation:** DATA_W=16, T_STROBE=1, T_GAP=1, 2-beat write.
  - B=6; done at k+14.
  - Strobe invariants hold on every cycle, checked by concurrent assertions.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed address/data bus master.
// State encodings are exported as-is on the bstate debug port.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    A_SETUP  = 4'd1,
    A_STROBE = 4'd2,
    A_HOLD   = 4'd3,
    D_SETUP  = 4'd4,
    D_STROBE = 4'd5,
    D_HOLD   = 4'd6,
    GAP      = 4'd7,
    DONE     = 4'd8
  } bus_state_t;

  localparam int DEF_T_SETUP  = 1;
  localparam int DEF_T_STROBE = 4;
  localparam int DEF_T_HOLD   = 1;
  localparam int DEF_T_GAP    = 2;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; last is high while the count is zero.
// Load takes effect on the next edge; no backpressure.
module rtc_phase_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// Burst bus master for the RTC multiplexed address/data pins; all outputs registered, first A_SETUP one cycle after accept.
// Backpressure: start is only accepted in IDLE and otherwise silently ignored.
module rtc_bus_master import rtc_bus_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_STROBE  = DEF_T_STROBE,
  parameter int T_HOLD    = DEF_T_HOLD,
  parameter int T_GAP     = DEF_T_GAP,
  parameter int MAX_BURST = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              rw,
  input  logic [DATA_W-1:0]                 addr,
  input  logic [clog2(MAX_BURST+1)-1:0]     len,
  input  logic [DATA_W-1:0]                 wdata,
  output logic                              wdata_ack,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              rdata_valid,
  output logic                              busy,
  output logic                              done,
  output logic                              ADo,
  output logic                              CSo,
  output logic                              RDo,
  output logic                              WRo,
  output logic [DATA_W-1:0]                 AdressDatao,
  input  logic [DATA_W-1:0]                 AdressData_in,
  output logic                              bus_oe,
  output logic [3:0]                        bstate
);

  localparam int LEN_W = clog2(MAX_BURST + 1);
  localparam int T_MAX01 = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int T_MAX23 = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
  localparam int TW      = (clog2(T_MAX) < 1) ? 1 : clog2(T_MAX);

  if (T_SETUP < 1 || T_STROBE < 1 || T_HOLD < 1 || T_GAP < 1) begin : g_bad_timing
    $error("rtc_bus_master: every T_* parameter must be >= 1");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("rtc_bus_master: MAX_BURST must be >= 1");
  end

  bus_state_t        state, nxt;
  logic [DATA_W-1:0] cur_addr, addr_nxt;
  logic [LEN_W-1:0]  beats_left, beats_nxt;
  logic              dir_rd, dir_nxt;
  logic              t_load, t_last;
  logic [TW-1:0]     t_val;

  // Timer holds (duration - 1) so that last marks the final cycle of a phase.
  function automatic logic [TW-1:0] dur(input bus_state_t s);
    case (s)
      A_SETUP, D_SETUP:   dur = TW'(T_SETUP - 1);
      A_STROBE, D_STROBE: dur = TW'(T_STROBE - 1);
      A_HOLD, D_HOLD:     dur = TW'(T_HOLD - 1);
      GAP:                dur = TW'(T_GAP - 1);
      default:            dur = '0;
    endcase
  endfunction

  rtc_phase_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .last     (t_last)
  );

  always_comb begin
    nxt       = state;
    addr_nxt  = cur_addr;
    beats_nxt = beats_left;
    dir_nxt   = dir_rd;
    case (state)
      IDLE: begin
        if (start) begin
          dir_nxt   = rw;
          addr_nxt  = addr;
          beats_nxt = (len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : len;
          nxt       = (len == '0) ? DONE : A_SETUP;
        end
      end
      A_SETUP:  if (t_last) nxt = A_STROBE;
      A_STROBE: if (t_last) nxt = A_HOLD;
      A_HOLD:   if (t_last) nxt = D_SETUP;
      D_SETUP:  if (t_last) nxt = D_STROBE;
      D_STROBE: if (t_last) nxt = D_HOLD;
      D_HOLD: begin
        if (t_last) begin
          addr_nxt  = cur_addr + 1'b1;
          beats_nxt = beats_left - 1'b1;
          nxt       = (beats_left == LEN_W'(1)) ? DONE : GAP;
        end
      end
      GAP:      if (t_last) nxt = A_SETUP;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    t_load = (nxt != state);
    t_val  = dur(nxt);
  end

  // Pin outputs are decoded from the next state so they line up with bstate.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      beats_left  <= '0;
      dir_rd      <= 1'b0;
      ADo         <= 1'b1;
      CSo         <= 1'b1;
      RDo         <= 1'b1;
      WRo         <= 1'b1;
      bus_oe      <= 1'b0;
      AdressDatao <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wdata_ack   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nxt;
      cur_addr    <= addr_nxt;
      beats_left  <= beats_nxt;
      dir_rd      <= dir_nxt;
      ADo         <= !(nxt == A_SETUP || nxt == A_STROBE);
      CSo         <= !(nxt == A_STROBE || nxt == D_STROBE);
      WRo         <= !(nxt == A_STROBE || (nxt == D_STROBE && !dir_nxt));
      RDo         <= !(nxt == D_STROBE && dir_nxt);
      busy        <= (nxt != IDLE);
      done        <= (nxt == DONE);
      wdata_ack   <= 1'b0;
      rdata_valid <= 1'b0;

      if (nxt inside {A_SETUP, A_STROBE, A_HOLD}) begin
        bus_oe      <= 1'b1;
        AdressDatao <= addr_nxt;
      end else if ((nxt inside {D_SETUP, D_STROBE, D_HOLD}) && !dir_nxt) begin
        bus_oe <= 1'b1;
        if (nxt == D_SETUP && state != D_SETUP) begin
          AdressDatao <= wdata;
          wdata_ack   <= 1'b1;
        end
      end else begin
        bus_oe      <= 1'b0;
        AdressDatao <= '0;
      end

      if (state == D_STROBE && t_last && dir_rd) begin
        rdata       <= AdressData_in;
        rdata_valid <= 1'b1;
      end
    end
  end

  assign bstate = state;

  a_no_rd_and_wr: assert property (@(posedge clock) disable iff (!reset) (RDo || WRo));
  a_no_oe_on_rd:  assert property (@(posedge clock) disable iff (!reset) (RDo || !bus_oe));
  a_data_no_ad:   assert property (@(posedge clock) disable iff (!reset)
                    ((state inside {D_SETUP, D_STROBE, D_HOLD}) -> (CSo || ADo)));

endmodule

// File: tb/tb_rtc_bus_master.sv
// Randomized bench for rtc_bus_master: pin-level monitor plus a chip memory model,
// compared against expectations derived from burst length, address wrap and phase timing.
module tb_rtc_bus_master;
  import rtc_bus_pkg::*;

  localparam int TS = 1, TST = 4, TH = 1, TG = 2, MAXB = 16;
  localparam int BEAT = 2 * (TS + TST + TH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, rw;
  logic [7:0] addr, wdata, AdressData_in, rdata, AdressDatao;
  logic [4:0] len;
  logic       wdata_ack, rdata_valid, busy, done, ADo, CSo, RDo, WRo, bus_oe;
  logic [3:0] bstate;

  logic        s_start, s_rw, s_wdata_ack, s_rdata_valid, s_busy, s_done;
  logic        s_ADo, s_CSo, s_RDo, s_WRo, s_bus_oe;
  logic [15:0] s_addr, s_wdata, s_rdata, s_dout, s_din;
  logic [4:0]  s_len;
  logic [3:0]  s_bstate;

  rtc_bus_master u_dut (
    .clock(clk), .reset(rst_n), .start(start), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .ADo(ADo), .CSo(CSo), .RDo(RDo), .WRo(WRo),
    .AdressDatao(AdressDatao), .AdressData_in(AdressData_in), .bus_oe(bus_oe), .bstate(bstate)
  );

  rtc_bus_master #(.DATA_W(16), .T_STROBE(1), .T_GAP(1)) u_dut16 (
    .clock(clk), .reset(rst_n), .start(s_start), .rw(s_rw), .addr(s_addr), .len(s_len),
    .wdata(s_wdata), .wdata_ack(s_wdata_ack), .rdata(s_rdata), .rdata_valid(s_rdata_valid),
    .busy(s_busy), .done(s_done), .ADo(s_ADo), .CSo(s_CSo), .RDo(s_RDo), .WRo(s_WRo),
    .AdressDatao(s_dout), .AdressData_in(s_din), .bus_oe(s_bus_oe), .bstate(s_bstate)
  );

  int n_tests = 0, n_fail = 0;
  logic [7:0] chip_mem [256];
  logic [7:0] ref_mem  [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input bit rd, input logic [7:0] a, input int l,
                         input logic [7:0] w0, input bit hold, input int rst_at);
    logic [7:0] wbuf[$], addr_obs[$], wr_obs[$], rd_obs[$];
    logic [7:0] bus_addr;
    int n, exp_done, done_cyc, done_cnt, ack_cnt, widx, wr_run, rd_run;
    int bad_len, inv, lows, limit, upd;
    bit prev_a, prev_w, a_cyc, w_cyc, d_st;
    n = (l > MAXB) ? MAXB : l;
    exp_done = (n == 0) ? 1 : 1 + n * BEAT + (n - 1) * TG;
    wbuf.push_back(w0);
    for (int i = 1; i < MAXB; i++) wbuf.push_back(8'($urandom));
    done_cyc = -1; done_cnt = 0; ack_cnt = 0; widx = 0; wr_run = 0; rd_run = 0;
    bad_len = 0; inv = 0; lows = 0; bus_addr = '0; prev_a = 0; prev_w = 0;
    limit = (rst_at >= 0) ? rst_at + 1 : exp_done + 20;

    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    chk("idle_before", {31'd0, busy}, 0);
    start = 1'b1; rw = rd; addr = a; len = 5'(l); wdata = w0;
    @(posedge clk);

    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        chk("rst_pins", {27'd0, ADo, CSo, RDo, WRo, bus_oe}, 32'b11110);
        chk("rst_state", {28'd0, bstate}, 32'(IDLE));
        chk("rst_flags", {28'd0, busy, done, wdata_ack, rdata_valid}, 0);
        chk("rst_bus", {24'd0, AdressDatao}, 0);
        chk("rst_rdata", {24'd0, rdata}, 0);
        rst_n = 1'b1;
        break;
      end
      if (cyc == 1) chk("busy_on", {31'd0, busy}, 1);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        start = 1'b0;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_drop", {31'd0, busy}, 0);
      a_cyc = !CSo && !ADo;
      w_cyc = !CSo && ADo && !WRo;
      if (a_cyc && !prev_a) begin
        addr_obs.push_back(AdressDatao);
        bus_addr = AdressDatao;
      end
      if (w_cyc && !prev_w) begin
        wr_obs.push_back(AdressDatao);
        chip_mem[bus_addr] = AdressDatao;
      end
      prev_a = a_cyc; prev_w = w_cyc;
      if (!WRo) wr_run++;
      else begin
        if (wr_run != 0 && wr_run != TST) bad_len++;
        wr_run = 0;
      end
      if (!RDo) rd_run++;
      else begin
        if (rd_run != 0 && rd_run != TST) bad_len++;
        rd_run = 0;
      end
      d_st = (bstate == 4'(D_SETUP)) || (bstate == 4'(D_STROBE)) || (bstate == 4'(D_HOLD));
      if (!CSo || !ADo || !RDo || !WRo) lows++;
      if (!RDo && !WRo) inv++;
      if (!RDo && bus_oe) inv++;
      if (d_st && !ADo) inv++;
      if (rd && d_st && bus_oe) inv++;
      if (rdata_valid) rd_obs.push_back(rdata);
      if (wdata_ack) begin
        ack_cnt++;
        widx++;
        if (widx < MAXB) wdata = wbuf[widx];
      end
      AdressData_in = chip_mem[bus_addr];
      if (rst_at >= 0 && cyc == rst_at) begin
        chk("rst_in_wr_strobe", {30'd0, ADo, WRo}, 32'b10);
        rst_n = 1'b0;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;

    if (rst_at >= 0) begin
      chk("rst_no_done", done_cnt, 0);
      upd = 2;
    end else begin
      upd = n;
      chk("done_lat", done_cyc, exp_done);
      chk("done_cnt", done_cnt, 1);
      chk("beats", addr_obs.size(), n);
      for (int i = 0; i < n; i++)
        if (i < addr_obs.size()) chk("addr", {24'd0, addr_obs[i]}, {24'd0, 8'(a + i)});
      if (rd) begin
        chk("rd_cnt", rd_obs.size(), n);
        chk("ack_none", ack_cnt, 0);
        for (int i = 0; i < n; i++)
          if (i < rd_obs.size()) chk("rdata", {24'd0, rd_obs[i]}, {24'd0, ref_mem[8'(a + i)]});
      end else begin
        chk("ack_cnt", ack_cnt, n);
        chk("wr_cnt", wr_obs.size(), n);
        for (int i = 0; i < n; i++)
          if (i < wr_obs.size()) chk("wdata", {24'd0, wr_obs[i]}, {24'd0, wbuf[i]});
      end
      chk("strobe_len", bad_len, 0);
      chk("invariants", inv, 0);
      if (n == 0) chk("no_strobes", lows, 0);
    end
    if (!rd) for (int i = 0; i < upd; i++) ref_mem[8'(a + i)] = wbuf[i];
  endtask

  task automatic run16();
    logic [15:0] ad[$], wd[$];
    logic [15:0] w0, w1;
    int done_cyc, acks;
    bit pa, pw, ac, wc;
    w0 = 16'($urandom); w1 = 16'($urandom);
    done_cyc = -1; acks = 0; pa = 0; pw = 0;
    s_start = 1'b1; s_rw = 1'b0; s_addr = 16'hFFFF; s_len = 5'd2; s_wdata = w0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_done && done_cyc < 0) done_cyc = cyc;
      ac = !s_CSo && !s_ADo;
      wc = !s_CSo && s_ADo && !s_WRo;
      if (ac && !pa) ad.push_back(s_dout);
      if (wc && !pw) wd.push_back(s_dout);
      pa = ac; pw = wc;
      if (s_wdata_ack) begin
        acks++;
        s_wdata = w1;
      end
      if (done_cyc >= 0) break;
    end
    chk("w16_done_lat", done_cyc, 14);
    chk("w16_acks", acks, 2);
    chk("w16_beats", ad.size(), 2);
    if (ad.size() == 2) begin
      chk("w16_addr0", {16'd0, ad[0]}, 32'h0000FFFF);
      chk("w16_addr1", {16'd0, ad[1]}, 32'h00000000);
    end
    chk("w16_wr_cnt", wd.size(), 2);
    if (wd.size() == 2) begin
      chk("w16_data0", {16'd0, wd[0]}, {16'd0, w0});
      chk("w16_data1", {16'd0, wd[1]}, {16'd0, w1});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; len = '0; wdata = '0; AdressData_in = '0;
    s_start = 1'b0; s_rw = 1'b0; s_addr = '0; s_len = '0; s_wdata = '0; s_din = '0;
    for (int i = 0; i < 256; i++) begin
      chip_mem[i] = 8'($urandom);
      ref_mem[i]  = chip_mem[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pins", {23'd0, ADo, CSo, RDo, WRo, bus_oe, busy, done, wdata_ack, rdata_valid},
        32'b111100000);
    chk("reset_state", {28'd0, bstate}, 32'(IDLE));
    chk("reset_bus", {16'd0, AdressDatao, rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 8'h21, 1, 8'h59, 1'b0, -1);
    chip_mem[8'h22] = 8'h37; ref_mem[8'h22] = 8'h37;
    run_txn(1'b1, 8'h22, 1, 8'h00, 1'b0, -1);
    run_txn(1'b1, 8'hFE, 3, 8'h00, 1'b0, -1);
    run_txn(1'b0, 8'h10, 0, 8'hAA, 1'b0, -1);
    run_txn(1'b0, 8'h40, 2, 8'($urandom), 1'b1, -1);
    run_txn(1'b1, 8'hF0, 20, 8'h00, 1'b0, -1);
    run_txn(1'b0, 8'h80, 4, 8'($urandom), 1'b0, 23);
    run_txn(1'b1, 8'h80, 2, 8'h00, 1'b0, -1);
    for (int t = 0; t < 24; t++)
      run_txn(1'($urandom), 8'($urandom), int'($urandom_range(0, 20)), 8'($urandom),
              1'($urandom), -1);
    run16();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
